// File: rtl/masked_sbox_pkg.sv
// Shared types, constants and affine helpers for the masked S-box sequencer.
// Affine maps are linear per share; constants are applied to share 0 only.
package masked_sbox_pkg;

  localparam int LAT_DEF    = 4;
  localparam int NBYTES_DEF = 16;

  localparam logic [7:0] AFF_C_ENC = 8'h63;
  localparam logic [7:0] AFF_C_DEC = 8'h05;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [7:0] rotl(
    input logic [7:0]  x,
    input int unsigned n
  );
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Forward SubBytes matrix, no constant.
  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4);
  endfunction

  // Inverse SubBytes matrix, no constant.
  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6);
  endfunction

endpackage

// File: rtl/masked_sbox_seq_affine.sv
// Per-share AES affine map: forward or inverse matrix, optional constant.
// Purely combinational; one instance never sees more than one share.
module aes_affine_share
  import masked_sbox_pkg::*;
(
  input  logic [7:0] x,
  input  logic       inv,
  input  logic       cen,
  output logic [7:0] y
);

  logic [7:0] lin;
  logic [7:0] cst;

  // linear map, then the mode constant when enabled
  always_comb begin
    lin = inv ? aff_inv(x) : aff_fwd(x);
    cst = inv ? AFF_C_DEC : AFF_C_ENC;
    y   = cen ? (lin ^ cst) : lin;
  end

endmodule

// File: rtl/masked_sbox_seq.sv
// Streams 16 two-share bytes through the masked inverse core and
// reassembles the results in issue order using a valid delay line.
module masked_sbox_seq
  import masked_sbox_pkg::*;
#(
  parameter int LAT    = LAT_DEF,
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dec,
  input  logic [8*NBYTES-1:0]   state_sh0,
  input  logic [8*NBYTES-1:0]   state_sh1,
  input  logic [11:0]           rnd_in,
  output logic [7:0]            core_a0,
  output logic [7:0]            core_a1,
  output logic [7:0]            core_guards,
  output logic [3:0]            core_random,
  output logic                  core_vld_o,
  input  logic [7:0]            core_v0,
  input  logic [7:0]            core_v1,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   out_sh0,
  output logic [8*NBYTES-1:0]   out_sh1
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [IW-1:0] ILAST = IW'(NBYTES - 1);
  localparam logic [CW-1:0] CLAST = CW'(NBYTES - 1);

  state_e state_q, state_d;

  logic [IW-1:0]  iss_q, iss_d, iss_nxt;
  logic [CW-1:0]  cap_q, cap_d;
  logic [LAT-1:0] pipe_q, pipe_d;
  logic           dec_q, dec_d;
  logic [W-1:0]   sh0_q, sh0_d;
  logic [W-1:0]   sh1_q, sh1_d;
  logic [W-1:0]   out0_q, out0_d;
  logic [W-1:0]   out1_q, out1_d;
  logic [7:0]     a0_q, a0_d;
  logic [7:0]     a1_q, a1_d;
  logic [7:0]     g_q, g_d;
  logic [3:0]     r_q, r_d;
  logic           vld_q, vld_d;

  logic       accept;
  logic       tail;
  logic       iss_dec;
  logic [7:0] iss_b0, iss_b1;
  logic [7:0] iss_f0, iss_f1;
  logic [7:0] cap_f0, cap_f1;
  logic [7:0] cap_b0, cap_b1;

  assign accept  = (state_q == IDLE) && start;
  assign tail    = pipe_q[LAT-1];
  assign iss_nxt = iss_q + IW'(1);

  // byte 0 comes straight from the ports so it is on the core one
  // cycle after start; later bytes come from the latched state
  always_comb begin
    if (accept) begin
      iss_b0  = state_sh0[7:0];
      iss_b1  = state_sh1[7:0];
      iss_dec = dec;
    end else begin
      iss_b0  = sh0_q[{iss_nxt, 3'b000} +: 8];
      iss_b1  = sh1_q[{iss_nxt, 3'b000} +: 8];
      iss_dec = dec_q;
    end
  end

  aes_affine_share u_iss0 (
    .x   (iss_b0),
    .inv (1'b1),
    .cen (1'b1),
    .y   (iss_f0)
  );

  aes_affine_share u_iss1 (
    .x   (iss_b1),
    .inv (1'b1),
    .cen (1'b0),
    .y   (iss_f1)
  );

  aes_affine_share u_cap0 (
    .x   (core_v0),
    .inv (1'b0),
    .cen (1'b1),
    .y   (cap_f0)
  );

  aes_affine_share u_cap1 (
    .x   (core_v1),
    .inv (1'b0),
    .cen (1'b0),
    .y   (cap_f1)
  );

  assign cap_b0 = dec_q ? core_v0 : cap_f0;
  assign cap_b1 = dec_q ? core_v1 : cap_f1;

  // issue, valid delay line and in-order capture
  always_comb begin
    iss_d  = iss_q;
    cap_d  = cap_q;
    dec_d  = dec_q;
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    out0_d = out0_q;
    out1_d = out1_q;
    a0_d   = a0_q;
    a1_d   = a1_q;
    g_d    = g_q;
    r_d    = r_q;
    vld_d  = 1'b0;
    pipe_d = {pipe_q[LAT-2:0], vld_q};

    if (accept) begin
      dec_d = dec;
      sh0_d = state_sh0;
      sh1_d = state_sh1;
      iss_d = '0;
      cap_d = '0;
    end

    if (accept || (state_q == FEED && iss_q != ILAST)) begin
      a0_d  = iss_dec ? iss_f0 : iss_b0;
      a1_d  = iss_dec ? iss_f1 : iss_b1;
      g_d   = rnd_in[7:0];
      r_d   = rnd_in[11:8];
      vld_d = 1'b1;
      if (!accept) begin
        iss_d = iss_nxt;
      end
    end

    if (tail) begin
      out0_d[{cap_q[IW-1:0], 3'b000} +: 8] = cap_b0;
      out1_d[{cap_q[IW-1:0], 3'b000} +: 8] = cap_b1;
      cap_d = cap_q + CW'(1);
    end
  end

  // next state; DONE is entered on the edge of the final capture
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FEED;
      FEED:    if (iss_q == ILAST) state_d = DRAIN;
      DRAIN:   if (tail && cap_q == CLAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // status outputs decoded from the state
  always_comb begin
    busy = (state_q == FEED) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iss_q   <= '0;
      cap_q   <= '0;
      pipe_q  <= '0;
      dec_q   <= 1'b0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      g_q     <= '0;
      r_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      pipe_q  <= pipe_d;
      dec_q   <= dec_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      g_q     <= g_d;
      r_q     <= r_d;
      vld_q   <= vld_d;
    end
  end

  assign core_a0     = a0_q;
  assign core_a1     = a1_q;
  assign core_guards = g_q;
  assign core_random = r_q;
  assign core_vld_o  = vld_q;
  assign out_sh0     = out0_q;
  assign out_sh1     = out1_q;

endmodule

// File: tb/tb_masked_sbox_seq.sv
// Bench for masked_sbox_seq with a remasking inverse-core model and
// a table-based S-box reference built from GF(2^8) arithmetic.
module tb_masked_sbox_seq;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         dec;
  logic [127:0] state_sh0, state_sh1;
  logic [11:0]  rnd_in;
  logic [7:0]   core_a0, core_a1, core_guards;
  logic [3:0]   core_random;
  logic         core_vld_o;
  logic [7:0]   core_v0, core_v1;
  logic         busy, done;
  logic [127:0] out_sh0, out_sh1;

  int checks = 0;
  int failures = 0;

  logic [7:0]   ginv  [256];
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [15:0]  st    [LAT];
  logic [7:0]   rq    [$];
  logic [11:0]  rnd_prev;
  logic [127:0] pe0, pe1;

  masked_sbox_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dec         (dec),
    .state_sh0   (state_sh0),
    .state_sh1   (state_sh1),
    .rnd_in      (rnd_in),
    .core_a0     (core_a0),
    .core_a1     (core_a1),
    .core_guards (core_guards),
    .core_random (core_random),
    .core_vld_o  (core_vld_o),
    .core_v0     (core_v0),
    .core_v1     (core_v1),
    .busy        (busy),
    .done        (done),
    .out_sh0     (out_sh0),
    .out_sh1     (out_sh1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rnd_in = 12'($urandom);
  always @(posedge clk) rnd_prev = rnd_in;

  // core model: unmask, invert, remask with a fresh byte, LAT-cycle delay
  always @(posedge clk) begin
    logic [7:0] r;
    r = 8'($urandom);
    for (int i = LAT - 1; i > 0; i--) st[i] <= st[i-1];
    st[0] <= {ginv[core_a0 ^ core_a1] ^ r, r};
    if (core_vld_o) rq.push_back(r);
  end

  assign core_v0 = st[LAT-1][15:8];
  assign core_v1 = st[LAT-1][7:0];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++)
      y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
    return y;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // one pass; mode 0 plain, 1 start pokes while busy/done, 2 reset at byte 7
  task automatic run_pass(input logic d, input logic [127:0] s0,
                          input logic [127:0] s1, input int mode);
    logic [127:0] e0, e1, eu;
    logic [7:0]   x, y, r, expi;
    int           k;
    rq.delete();
    @(negedge clk);
    start = 1'b1;
    dec = d;
    state_sh0 = s0;
    state_sh1 = s1;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      chk("vld", 128'(core_vld_o), 128'(n <= 16));
      chk("busy", 128'(busy), 128'(n < LAT + 17));
      chk("done", 128'(done), 128'(n == LAT + 17));
      if (n <= 16) begin
        k = n - 1;
        x = s0[8*k +: 8] ^ s1[8*k +: 8];
        expi = d ? ginv[isbox[x]] : x;
        chk("issue", 128'(core_a0 ^ core_a1), 128'(expi));
        chk("rnd", 128'({core_random, core_guards}), 128'(rnd_prev));
      end
      if (n <= LAT + 1) begin
        chk("hold0", out_sh0, pe0);
        chk("hold1", out_sh1, pe1);
      end
      if (n == LAT + 17) begin
        chk("remask_cnt", 128'(rq.size()), 128'd16);
        for (int j = 0; j < 16; j++) begin
          x = s0[8*j +: 8] ^ s1[8*j +: 8];
          y = d ? isbox[x] : ginv[x];
          r = (rq.size() != 0) ? rq.pop_front() : 8'h00;
          e0[8*j +: 8] = d ? (y ^ r) : (aff(y ^ r) ^ 8'h63);
          e1[8*j +: 8] = d ? r : aff(r);
          eu[8*j +: 8] = d ? isbox[x] : sbox[x];
        end
        chk("out_sh0", out_sh0, e0);
        chk("out_sh1", out_sh1, e1);
        chk("unmasked", out_sh0 ^ out_sh1, eu);
        pe0 = e0;
        pe1 = e1;
      end
      if (mode == 1 && (n == 5 || n == 18 || n == LAT + 17)) begin
        start = 1'b1;
        dec = ~d;
        state_sh0 = ~s0;
        state_sh1 = {4{$urandom}};
      end
      if (mode == 2 && n == 8) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 128'({core_a0, core_a1, core_guards, core_random,
                             core_vld_o, busy, done}), 128'd0);
        chk("rst_out0", out_sh0, 128'd0);
        chk("rst_out1", out_sh1, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rq.delete();
        pe0 = '0;
        pe1 = '0;
        return;
      end
    end
  endtask

  initial begin
    logic [127:0] s0, s1, u;
    logic [7:0]   b;
    for (int i = 0; i < LAT; i++) st[i] = 16'h0;
    ginv[0] = 8'h00;
    for (int a = 1; a < 256; a++)
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) ginv[a] = 8'(c);
    for (int a = 0; a < 256; a++) begin
      b = aff(ginv[a]) ^ 8'h63;
      sbox[a] = b;
      isbox[b] = 8'(a);
    end
    chk("model_sbox53", 128'(sbox[8'h53]), 128'h ed);
    chk("model_isbox00", 128'(isbox[8'h00]), 128'h52);

    pe0 = '0;
    pe1 = '0;
    rst_n = 1'b0;
    start = 1'b0;
    dec = 1'b0;
    state_sh0 = '0;
    state_sh1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 128'({core_a0, core_a1, core_guards, core_random,
                           core_vld_o, busy, done}), 128'd0);
    chk("reset_out", out_sh0 | out_sh1, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) s0[8*i +: 8] = 8'(i);
    run_pass(1'b0, s0, 128'd0, 0);
    u = out_sh0 ^ out_sh1;
    chk("lit_b0", 128'(u[7:0]), 128'h63);
    chk("lit_b1", 128'(u[15:8]), 128'h7c);
    chk("lit_b15", 128'(u[127:120]), 128'h76);

    s1 = {$urandom, $urandom, $urandom, $urandom};
    run_pass(1'b1, s1 ^ {16{8'h63}}, s1, 0);
    chk("lit_dec63", out_sh0 ^ out_sh1, 128'd0);
    s1 = {$urandom, $urandom, $urandom, $urandom};
    run_pass(1'b1, s1 ^ {16{8'h7c}}, s1, 0);
    chk("lit_dec7c", out_sh0 ^ out_sh1, {16{8'h01}});

    s0 = {$urandom, $urandom, $urandom, $urandom};
    s1 = {$urandom, $urandom, $urandom, $urandom};
    run_pass(1'b0, s0, s1, 1);
    run_pass(1'b1, s1, s0, 1);

    run_pass(1'b0, s0, s1, 2);
    run_pass(1'b0, s0, s1, 0);
    run_pass(1'b1, s0, s1, 2);
    run_pass(1'b1, s1, s0, 0);

    for (int t = 0; t < 1000; t++) begin
      s0 = {$urandom, $urandom, $urandom, $urandom};
      s1 = {$urandom, $urandom, $urandom, $urandom};
      run_pass(1'($urandom), s0, s1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
